// File: rtl/snake_sprite_sequencer.sv
// snake_sprite_sequencer: frame-synchronous sprite selection for the snake.
// Latches direction requests and commits them only at frame start. Steps the
// two-phase walk animation while moving. Drives the sprite ROM base address.
module snake_sprite_sequencer #(
  parameter int unsigned ANIM_DIV     = 8,
  parameter int unsigned SPRITE_WORDS = 945
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        moving,
  input  logic [1:0]  dir_req,
  input  logic        dir_valid,
  output logic        dir_accept,
  output logic        dir_reject,
  output logic        frame_tick,
  output logic [2:0]  sprite_sel,
  output logic [12:0] rom_base,
  output logic [1:0]  cur_dir
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [7:0]  ANIM_LAST = 8'(ANIM_DIV - 1);
  localparam logic [12:0] SW        = 13'(SPRITE_WORDS);
  localparam logic [12:0] ROM_RST   = 13'(2 * SPRITE_WORDS);

  logic        r_vs1;
  logic        r_vs2;
  logic        r_tick_evt;
  logic        w_edge;
  logic        w_req_opp;
  logic        w_req_take;
  logic        r_pend_valid;
  logic [1:0]  r_pend_dir;
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_phase;
  logic        w_phase_nxt;
  logic [7:0]  r_anim_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [1:0]  r_cur_dir;
  logic [1:0]  w_dir_nxt;
  logic [2:0]  r_sprite_sel;
  logic [2:0]  w_sel_nxt;
  logic [12:0] r_rom_base;
  logic [12:0] w_rom_nxt;
  logic        r_frame_tick;
  logic        r_dir_accept;
  logic        r_dir_reject;

  assign w_edge     = r_vs2 & ~r_vs1;
  assign w_req_opp  = (dir_req[1] == r_cur_dir[1]) && (dir_req[0] != r_cur_dir[0]);
  assign w_req_take = dir_valid & ~w_req_opp;

  // VSYNC synchroniser and falling-edge detect. The detected edge is held one
  // more cycle so that the commit lands two edges after vsync is first seen low.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_vs1      <= 1'b1;
      r_vs2      <= 1'b1;
      r_tick_evt <= 1'b0;
    end else begin
      r_vs1      <= vsync;
      r_vs2      <= r_vs1;
      r_tick_evt <= w_edge;
    end
  end

  // Request filter and the single pending slot: the newest accepted request
  // wins, and one arriving on the commit cycle survives into the next frame.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_dir   <= 2'd0;
      r_dir_accept <= 1'b0;
      r_dir_reject <= 1'b0;
    end else begin
      r_dir_accept <= w_req_take;
      r_dir_reject <= dir_valid & w_req_opp;
      if (w_req_take) begin
        r_pend_valid <= 1'b1;
        r_pend_dir   <= dir_req;
      end else if (r_tick_evt) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Next-state logic: animation FSM step, then a direction commit that
  // overrides the animation step on the same frame tick.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_anim_cnt;
    w_dir_nxt   = r_cur_dir;
    if (r_tick_evt) begin
      unique case (r_state)
        S_IDLE: begin
          w_phase_nxt = 1'b0;
          w_cnt_nxt   = '0;
          if (moving) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!moving) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end else if (r_anim_cnt == ANIM_LAST) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
          end else begin
            w_cnt_nxt   = r_anim_cnt + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (r_pend_valid && (r_pend_dir != r_cur_dir)) begin
        w_dir_nxt   = r_pend_dir;
        w_phase_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    end
    w_sel_nxt = {w_dir_nxt, w_phase_nxt};
    w_rom_nxt = 13'(w_sel_nxt) * SW;
  end

  // State, sprite selection and registered ROM base update together.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_phase      <= 1'b0;
      r_anim_cnt   <= '0;
      r_cur_dir    <= 2'd1;
      r_sprite_sel <= 3'b010;
      r_rom_base   <= ROM_RST;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_anim_cnt   <= w_cnt_nxt;
      r_cur_dir    <= w_dir_nxt;
      r_sprite_sel <= w_sel_nxt;
      r_rom_base   <= w_rom_nxt;
      r_frame_tick <= r_tick_evt;
    end
  end

  assign dir_accept = r_dir_accept;
  assign dir_reject = r_dir_reject;
  assign frame_tick = r_frame_tick;
  assign sprite_sel = r_sprite_sel;
  assign rom_base   = r_rom_base;
  assign cur_dir    = r_cur_dir;

endmodule

// File: tb/tb_snake_sprite_sequencer.sv
// Scoreboard bench for snake_sprite_sequencer with ANIM_DIV=4.
module tb_snake_sprite_sequencer;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync = 1'b1;
  logic        moving = 1'b0;
  logic [1:0]  dir_req = 2'd0;
  logic        dir_valid = 1'b0;
  logic        dir_accept;
  logic        dir_reject;
  logic        frame_tick;
  logic [2:0]  sprite_sel;
  logic [12:0] rom_base;
  logic [1:0]  cur_dir;

  snake_sprite_sequencer #(.ANIM_DIV(4), .SPRITE_WORDS(945)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .vsync(vsync), .moving(moving),
    .dir_req(dir_req), .dir_valid(dir_valid), .dir_accept(dir_accept),
    .dir_reject(dir_reject), .frame_tick(frame_tick), .sprite_sel(sprite_sel),
    .rom_base(rom_base), .cur_dir(cur_dir)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [2:0]  sel;
    logic [12:0] rom;
    logic [1:0]  dir;
  } tick_exp_t;

  tick_exp_t   tick_q[$];
  logic        req_q[$];   // 1 = accept expected, 0 = reject expected
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [17:0] last_out;
  tick_exp_t   te;
  logic        re;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a tick or request pulse.
  always @(negedge vga_clk) begin
    if (mon_en && reset_n) begin
      if (frame_tick) begin
        if (tick_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tick: got sel=%0d rom=%0d expected no tick", sprite_sel, rom_base);
        end else begin
          te = tick_q.pop_front();
          check("tick_sel", 32'(sprite_sel), 32'(te.sel));
          check("tick_rom", 32'(rom_base), 32'(te.rom));
          check("tick_dir", 32'(cur_dir), 32'(te.dir));
        end
      end else begin
        check("stable_outputs", 32'({sprite_sel, rom_base, cur_dir}), 32'(last_out));
      end
      if (dir_accept || dir_reject) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req_pulse: got acc=%0d rej=%0d expected none", dir_accept, dir_reject);
        end else begin
          re = req_q.pop_front();
          check("req_pulse", 32'({dir_accept, dir_reject}), re ? 32'd2 : 32'd1);
        end
      end
    end
    last_out = {sprite_sel, rom_base, cur_dir};
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic push_tick(input logic [2:0] s, input logic [12:0] r, input logic [1:0] d);
    tick_exp_t t;
    t.sel = s; t.rom = r; t.dir = d;
    tick_q.push_back(t);
  endtask

  // One vsync low pulse; optionally issues a request on the commit cycle.
  task automatic frame(input int low_n, input bit edge_req, input logic [1:0] edge_dir);
    vsync = 1'b0;
    @(negedge vga_clk);
    check("tick_T", 32'(frame_tick), 32'd0);
    @(negedge vga_clk);
    check("tick_T1", 32'(frame_tick), 32'd0);
    if (edge_req) begin
      dir_req = edge_dir;
      dir_valid = 1'b1;
    end
    @(negedge vga_clk);
    check("tick_T2", 32'(frame_tick), 32'd1);
    dir_valid = 1'b0;
    @(negedge vga_clk);
    check("tick_width", 32'(frame_tick), 32'd0);
    cyc(low_n - 4);
    vsync = 1'b1;
    cyc(12);
  endtask

  task automatic request(input logic [1:0] d, input bit acc);
    req_q.push_back(acc);
    dir_req = d;
    dir_valid = 1'b1;
    @(negedge vga_clk);
    dir_valid = 1'b0;
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  anim_sel [10] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2};
    logic [12:0] anim_rom [10] = '{13'd1890, 13'd1890, 13'd1890, 13'd1890, 13'd2835,
                                   13'd2835, 13'd2835, 13'd2835, 13'd1890, 13'd1890};
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
    check("rst_sel", 32'(sprite_sel), 32'd2);
    check("rst_rom", 32'(rom_base), 32'd1890);
    check("rst_dir", 32'(cur_dir), 32'd1);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_pulses", 32'({dir_accept, dir_reject}), 32'd0);
    mon_en = 1'b1;
    cyc(100);

    // Animation: tick 1 enters RUN, phase toggles on ticks 5 and 9.
    moving = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_tick(anim_sel[i], anim_rom[i], 2'd1);
      frame(6, 1'b0, 2'd0);
    end

    // Turn right mid-frame.
    cyc(3);
    request(2'd3, 1'b1);
    cyc(5);
    check("pre_commit_sel", 32'(sprite_sel), 32'd2);
    push_tick(3'd6, 13'd5670, 2'd3);
    frame(6, 1'b0, 2'd0);

    // Reverse (left while right) is rejected; next tick only animates.
    request(2'd2, 1'b0);
    push_tick(3'd6, 13'd5670, 2'd3);
    frame(6, 1'b0, 2'd0);

    // Turn up, then last-wins: 0 then 2 commits 2.
    request(2'd0, 1'b1);
    push_tick(3'd0, 13'd0, 2'd0);
    frame(6, 1'b0, 2'd0);
    request(2'd0, 1'b1);
    request(2'd2, 1'b1);
    push_tick(3'd4, 13'd3780, 2'd2);
    frame(6, 1'b0, 2'd0);

    // Request on the commit cycle waits for the following tick.
    req_q.push_back(1'b1);
    push_tick(3'd4, 13'd3780, 2'd2);
    frame(6, 1'b1, 2'd1);
    push_tick(3'd2, 13'd1890, 2'd1);
    frame(6, 1'b0, 2'd0);

    // Walk to phase 1, then stop on a long vsync low.
    for (int i = 0; i < 3; i++) begin
      push_tick(3'd2, 13'd1890, 2'd1);
      frame(6, 1'b0, 2'd0);
    end
    push_tick(3'd3, 13'd2835, 2'd1);
    frame(6, 1'b0, 2'd0);
    moving = 1'b0;
    push_tick(3'd2, 13'd1890, 2'd1);
    frame(40, 1'b0, 2'd0);

    // Reset with a pending request and a coincident request strobe.
    moving = 1'b1;
    request(2'd2, 1'b1);
    reset_n = 1'b0;
    dir_req = 2'd3;
    dir_valid = 1'b1;
    @(negedge vga_clk);
    check("rst_no_pulse", 32'({dir_accept, dir_reject}), 32'd0);
    reset_n = 1'b1;
    dir_valid = 1'b0;
    @(negedge vga_clk);
    check("rst2_sel", 32'(sprite_sel), 32'd2);
    check("rst2_rom", 32'(rom_base), 32'd1890);
    check("rst2_dir", 32'(cur_dir), 32'd1);
    push_tick(3'd2, 13'd1890, 2'd1);
    frame(6, 1'b0, 2'd0);

    cyc(5);
    check("tick_q_empty", 32'(tick_q.size()), 32'd0);
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
